rom_stream_reader: RTL and testbench

- Read-side controller for the team's 1024x8 synchronous ROM.
- On a start pulse it reads LENGTH consecutive words from BASE, drives the ROM address/enable pins, and captures the 1-cycle-latency ROM data.
- Captured words go out on a valid/ready byte stream with full backpressure.
- Sits between the ROM and any downstream consumer (UART TX, display driver).

---
 rtl/rom_stream_reader_pkg.sv | 18 +
 rtl/rom_stream_reader_fifo.sv | 48 ++++
 rtl/rom_stream_reader.sv | 102 ++++++++++
 tb/tb_rom_stream_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and encodings for the ROM stream reader.
package rom_reader_pkg;

  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 8;

  // rom_enable is a blanking control: high forces the ROM output to zero.
  localparam logic ROM_BLANK = 1'b1;
  localparam logic ROM_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count and registered head-valid.
// Head data is visible combinationally from storage; push/pop on one edge keep count.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             pop_ok;

  assign pop_ok    = pop && head_valid;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Streams LENGTH words from a 1-cycle-latency ROM starting at BASE onto valid/ready.
// First word valid 3 edges after start; issue throttles so buffer plus in-flight never exceed BUF_DEPTH.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining;
  logic [1:0]        rd_vld;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W-1:0]  in_flight;
  logic              issue;
  logic              pop;

  // Conservative: a pop on the same edge is not credited back.
  assign in_flight = CNT_W'(rd_vld[0]) + CNT_W'(rd_vld[1]);
  assign issue     = (state == ST_READ) && (remaining != '0) &&
                     ((buf_count + in_flight) < CNT_W'(BUF_DEPTH));
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_enable <= ROM_BLANK;
      rom_addr   <= '0;
      next_addr  <= '0;
      remaining  <= '0;
      rd_vld     <= '0;
    end else begin
      done       <= 1'b0;
      rom_enable <= ROM_BLANK;
      rd_vld     <= {rd_vld[0], issue};
      if (issue) begin
        rom_addr   <= next_addr;
        rom_enable <= ROM_READ;
        next_addr  <= next_addr + ADDR_W'(1);
        remaining  <= remaining - (ADDR_W+1)'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            next_addr <= base_addr;
            remaining <= length;
            busy      <= 1'b1;
            state     <= (length == '0) ? ST_FINISH : ST_READ;
          end
        end
        ST_READ: begin
          if (issue && remaining == (ADDR_W+1)'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // rd_vld covers a push landing on this same edge.
          if (rd_vld == 2'b00 && buf_count == '0) state <= ST_FINISH;
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_vld[1]),
    .push_data  (rom_data),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed scenarios with randomized backpressure against a word-queue model of the ROM stream.
module tb_rom_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] rom_addr;
  logic          rom_enable;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_enable (rom_enable),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'(i);
  always @(posedge clk) rom_data <= rom_enable ? '0 : rom_mem[rom_addr];

  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int issued = 0;
  int accepted = 0;
  int n_done = 0;
  int first_acc = -1;
  int last_acc = -1;
  int stall_left = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
  endtask

  task automatic load(input int base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(DW'((base + k) % (1 << AW)));
      exp_addr_q.push_back(AW'((base + k) % (1 << AW)));
    end
    first_acc = -1;
    last_acc  = -1;
  endtask

  task automatic cycle();
    logic          xfer, stall, busy_prev;
    logic [DW-1:0] xd;
    int            held_before;
    xfer        = out_valid && out_ready;
    stall       = out_valid && !out_ready;
    xd          = out_data;
    busy_prev   = busy;
    held_before = issued - accepted;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) begin
      accepted++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
      else chk("out_data", xd, exp_q.pop_front());
    end
    if (stall) begin
      chk("stall_valid_hold", out_valid, 1);
      chk("stall_data_hold", out_data, xd);
    end
    if (rom_enable == 1'b0) begin
      issued++;
      if (exp_addr_q.size() == 0) chk("extra_issue", exp_addr_q.size(), 1);
      else chk("rom_addr", rom_addr, exp_addr_q.pop_front());
    end
    if (held_before >= DEPTH) chk("blank_when_full", rom_enable, 1);
    if (issued - accepted > DEPTH) chk("occupancy", issued - accepted, DEPTH);
    if (done) begin
      n_done++;
      chk("busy_low_at_done", busy, 0);
      chk("busy_high_before_done", busy_prev, 1);
    end
  endtask

  task automatic drive_ready(input int mode);
    if (mode == 0) out_ready = 1'b1;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 7) == 0) begin
      out_ready  = 1'b0;
      stall_left = 4;
    end else out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_done(input int mode, input int budget, input string tag);
    int d0, n;
    d0 = n_done;
    n  = 0;
    while (n_done == d0 && n < budget) begin
      drive_ready(mode);
      cycle();
      n++;
    end
    chk({tag, "_done_seen"}, n_done - d0, 1);
    out_ready = 1'b1;
    repeat (4) cycle();
    chk({tag, "_single_done"}, n_done - d0, 1);
    chk({tag, "_all_words"}, exp_q.size(), 0);
    chk({tag, "_all_issued"}, exp_addr_q.size(), 0);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic kick(input int base, input int len);
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    start     = 1'b1;
    load(base, len);
    cycle();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  initial begin
    int a0, i0, d0;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_enable", rom_enable, 1);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    repeat (2) cycle();

    // Basic transfer with latency check.
    kick(10, 4);
    cycle(); chk("lat_edge1_valid", out_valid, 0);
    cycle(); chk("lat_edge2_valid", out_valid, 0);
    cycle(); chk("lat_edge3_valid", out_valid, 1);
    chk("lat_first_data", out_data, 10);
    wait_done(0, 50, "basic");
    chk("basic_back_to_back", last_acc - first_acc, 3);

    // Address wrap at the top of the ROM.
    kick(1022, 4);
    wait_done(0, 50, "wrap");

    // Randomized backpressure with long stalls.
    a0 = accepted;
    kick(0, 16);
    wait_done(1, 2000, "bp");
    chk("bp_count", accepted - a0, 16);

    // Zero length.
    a0 = accepted; i0 = issued;
    kick(0, 0);
    wait_done(0, 20, "zero");
    chk("zero_no_words", accepted - a0, 0);
    chk("zero_no_issue", issued - i0, 0);

    // Start while busy must be ignored.
    kick(40, 6);
    cycle();
    base_addr = AW'(100); length = (AW+1)'(3); start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    wait_done(0, 60, "busystart");

    // Reset in the middle of a transfer.
    a0 = accepted; d0 = n_done;
    kick(0, 20);
    for (int n = 0; n < 60 && accepted - a0 < 5; n++) cycle();
    chk("pre_rst_words", accepted - a0, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rom_enable", rom_enable, 1);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    exp_q.delete(); exp_addr_q.delete();
    issued = 0; accepted = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) cycle();
    chk("no_done_after_rst", n_done - d0, 0);
    chk("flushed_valid", out_valid, 0);
    kick(300, 2);
    wait_done(0, 40, "post_rst");

    // Whole ROM from the middle, wrapping.
    a0 = accepted;
    kick(512, 1024);
    wait_done(0, 1200, "full");
    chk("full_count", accepted - a0, 1024);
    chk("full_back_to_back", last_acc - first_acc, 1023);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
